// File: rtl/boreal_spi_chain_gen_if.sv
// SPI/DRDY pin bundle between the frame reader (master) and the ADS1299 chain (slave).
interface boreal_spi_chain_gen_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic drdy_n;

    modport master (output sclk, output cs_n, output mosi, input miso, input drdy_n);
    modport slave  (input sclk, input cs_n, input mosi, output miso, output drdy_n);
endinterface

// File: rtl/boreal_spi_chain_gen.sv
// ADS1299 daisy-chain frame reader: one full chain frame per DRDY falling edge, with per-device
// status checks, overrun detection and an enable gate.
module boreal_spi_chain_gen #(
    parameter int          N_DEV       = 4,
    parameter int          N_CH        = 8,
    parameter int          SAMPLE_BITS = 24,
    parameter int          STATUS_BITS = 24,
    parameter int          CLK_DIV     = 2,
    parameter int          CS_SETUP    = 4,
    parameter int          CS_HOLD     = 4,
    parameter logic [15:0] TXN_INIT    = 16'h0000,
    localparam int         DEV_BITS    = STATUS_BITS + N_CH * SAMPLE_BITS,
    localparam int         FRAME_BITS  = N_DEV * DEV_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clr_err,
    boreal_spi_chain_gen_if.master    spi,
    output logic [FRAME_BITS-1:0]     data_out,
    output logic                      data_valid,
    output logic [N_DEV-1:0]          status_ok,
    output logic                      overrun,
    output logic [15:0]               overrun_count,
    output logic [15:0]               txn_count,
    output logic [2:0]                state_dbg
);
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                             ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                             : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SU_LAST  = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CS_SU = 3'd1,
        SHIFT = 3'd2,
        CS_HD = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic                  drdy_s1, drdy_s2, drdy_prev;
    logic                  drdy_fall;
    logic [CNT_W-1:0]      cnt, cnt_last;
    logic                  cnt_hit;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  sclk_q, cs_n_q;
    logic                  start, sclk_fall, last_bit, frame_end, ovr_evt;
    logic [N_DEV-1:0]      status_new;

    assign spi.sclk  = sclk_q;
    assign spi.cs_n  = cs_n_q;
    assign spi.mosi  = 1'b0;
    assign state_dbg = state;

    // drdy_n is asynchronous to clk; only the synchronized copy feeds the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drdy_s1   <= 1'b1;
            drdy_s2   <= 1'b1;
            drdy_prev <= 1'b1;
        end else begin
            drdy_s1   <= spi.drdy_n;
            drdy_s2   <= drdy_s1;
            drdy_prev <= drdy_s2;
        end
    end

    assign drdy_fall = drdy_prev & ~drdy_s2;

    always_comb begin
        cnt_last = DIV_LAST;
        case (state)
            CS_SU:   cnt_last = SU_LAST;
            CS_HD:   cnt_last = HD_LAST;
            default: cnt_last = DIV_LAST;
        endcase
        cnt_hit   = (cnt == cnt_last);
        start     = (state == IDLE) && drdy_fall && enable;
        sclk_fall = (state == SHIFT) && cnt_hit && sclk_q;
        last_bit  = sclk_fall && (bit_cnt == BIT_LAST);
        frame_end = (state == CS_HD) && cnt_hit;
        ovr_evt   = drdy_fall && (state != IDLE);

        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = CS_SU;
            CS_SU:   if (cnt_hit)   state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = CS_HD;
            CS_HD:   if (frame_end) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        status_new = '0;
        for (int d = 0; d < N_DEV; d++) begin
            status_new[d] = (shift_reg[FRAME_BITS-1-d*DEV_BITS -: 4] == 4'hC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) cs_n_q <= 1'b0;
                end
                CS_SU: begin
                    if (cnt_hit) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_hit) begin
                        cnt    <= '0;
                        sclk_q <= ~sclk_q;
                        // CPHA=1: capture in the cycle sclk is driven low.
                        if (sclk_q) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], spi.miso};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_HD: begin
                    if (cnt_hit) begin
                        cnt    <= '0;
                        cs_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Results publish on entry to DONE so data_valid is high exactly during that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            status_ok  <= '0;
            txn_count  <= TXN_INIT;
        end else begin
            data_valid <= frame_end;
            if (frame_end) begin
                data_out  <= shift_reg;
                status_ok <= status_new;
                txn_count <= txn_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (ovr_evt) begin
                overrun <= 1'b1;
                if (overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_boreal_spi_chain_gen.sv
// Directed bench for boreal_spi_chain_gen: default 4x8 chain plus a 1x4, CLK_DIV=1 instance.
`timescale 1ns/1ps
module tb_boreal_spi_chain_gen;
  localparam int FB_A = 864;
  localparam int FB_B = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic clr_err = 1'b0;

  boreal_spi_chain_gen_if spi_a();
  boreal_spi_chain_gen_if spi_b();

  logic [FB_A-1:0] data_out_a;
  logic            data_valid_a;
  logic [3:0]      status_ok_a;
  logic            overrun_a;
  logic [15:0]     overrun_count_a, txn_count_a;
  logic [2:0]      state_a;

  logic [FB_B-1:0] data_out_b;
  logic            data_valid_b;
  logic [0:0]      status_ok_b;
  logic            overrun_b;
  logic [15:0]     overrun_count_b, txn_count_b;
  logic [2:0]      state_b;

  int total = 0;
  int bad = 0;

  boreal_spi_chain_gen dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err), .spi(spi_a.master),
    .data_out(data_out_a), .data_valid(data_valid_a), .status_ok(status_ok_a),
    .overrun(overrun_a), .overrun_count(overrun_count_a), .txn_count(txn_count_a),
    .state_dbg(state_a)
  );

  boreal_spi_chain_gen #(.N_DEV(1), .N_CH(4), .CLK_DIV(1), .TXN_INIT(16'hFFFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err), .spi(spi_b.master),
    .data_out(data_out_b), .data_valid(data_valid_b), .status_ok(status_ok_b),
    .overrun(overrun_b), .overrun_count(overrun_count_b), .txn_count(txn_count_b),
    .state_dbg(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ADC chain models: next bit presented on each SCLK rise, MSB of frame first
  logic [FB_A-1:0] frame_a = '0;
  logic [FB_B-1:0] frame_b = '0;
  int idx_a = 0, idx_b = 0;
  int rise_a = 0, rise_b = 0, vcnt_a = 0, vcnt_b = 0, csf_cnt_a = 0;
  time t_csf_a, t_r1_a, t_r2_a, t_fall_a, t_csr_a;
  time t_csf_b, t_r1_b, t_r2_b, t_fall_b, t_csr_b;

  initial begin
    spi_a.miso = 1'b0; spi_a.drdy_n = 1'b1;
    spi_b.miso = 1'b0; spi_b.drdy_n = 1'b1;
  end

  always @(negedge spi_a.cs_n) begin
    idx_a = 0; rise_a = 0; csf_cnt_a++; t_csf_a = $time;
  end
  always @(posedge spi_a.sclk) begin
    if (idx_a < FB_A) spi_a.miso = frame_a[FB_A-1-idx_a];
    idx_a++; rise_a++;
    if (rise_a == 1) t_r1_a = $time;
    if (rise_a == 2) t_r2_a = $time;
  end
  always @(negedge spi_a.sclk) t_fall_a = $time;
  always @(posedge spi_a.cs_n) t_csr_a = $time;
  always @(negedge clk) if (data_valid_a) vcnt_a++;

  always @(negedge spi_b.cs_n) begin
    idx_b = 0; rise_b = 0; t_csf_b = $time;
  end
  always @(posedge spi_b.sclk) begin
    if (idx_b < FB_B) spi_b.miso = frame_b[FB_B-1-idx_b];
    idx_b++; rise_b++;
    if (rise_b == 1) t_r1_b = $time;
    if (rise_b == 2) t_r2_b = $time;
  end
  always @(negedge spi_b.sclk) t_fall_b = $time;
  always @(posedge spi_b.cs_n) t_csr_b = $time;
  always @(negedge clk) if (data_valid_b) vcnt_b++;

  // expected frame: device d status (C00000, or 800000 if d==bad_dev), then samples {d,c,0000}
  function automatic logic [FB_A-1:0] mk_frame(input int n_dev, input int n_ch, input int bad_dev);
    logic [FB_A-1:0] f;
    logic [23:0] w;
    f = '0;
    for (int d = 0; d < n_dev; d++) begin
      w = (d == bad_dev) ? 24'h800000 : 24'hC00000;
      f = {f[FB_A-25:0], w};
      for (int c = 0; c < n_ch; c++) begin
        w = {4'(d), 4'(c), 16'h0000};
        f = {f[FB_A-25:0], w};
      end
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [FB_A-1:0] got, input logic [FB_A-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_drdy_a();
    @(negedge clk); spi_a.drdy_n = 1'b0;
    repeat (3) @(negedge clk);
    spi_a.drdy_n = 1'b1;
  endtask

  task automatic pulse_drdy_b();
    @(negedge clk); spi_b.drdy_n = 1'b0;
    repeat (3) @(negedge clk);
    spi_b.drdy_n = 1'b1;
  endtask

  task automatic wait_valid_a(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (data_valid_a) break;
    end
    chk(tag, data_valid_a, 1'b1);
  endtask

  task automatic wait_valid_b(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (data_valid_b) break;
    end
    chk(tag, data_valid_b, 1'b1);
  endtask

  task automatic wait_bit_a(input string tag, input int target);
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (rise_a >= target) break;
    end
    chk(tag, rise_a, target);
  endtask

  initial begin
    logic [FB_A-1:0] tmp;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", spi_a.sclk, 1'b0);
    chk("rst_cs_n", spi_a.cs_n, 1'b1);
    chk("rst_mosi", spi_a.mosi, 1'b0);
    chk("rst_data_out", data_out_a, '0);
    chk("rst_valid", data_valid_a, 1'b0);
    chk("rst_status", status_ok_a, 4'h0);
    chk("rst_overrun", overrun_a, 1'b0);
    chk("rst_ovr_cnt", overrun_count_a, 16'h0);
    chk("rst_txn", txn_count_a, 16'h0);
    chk("rst_state", state_a, 3'd0);
    chk("rst_txn_b", txn_count_b, 16'hFFFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: clean frame at defaults
    frame_a = mk_frame(4, 8, -1);
    vcnt_a = 0;
    pulse_drdy_a();
    wait_valid_a("t1_valid", 5000);
    chk("t1_data", data_out_a, frame_a);
    chk("t1_status", status_ok_a, 4'hF);
    chk("t1_txn", txn_count_a, 16'd1);
    repeat (10) @(negedge clk);
    chk("t1_vcnt", vcnt_a, 1);
    chk("t1_rises", rise_a, 864);
    chk("t1_period", (t_r2_a - t_r1_a) / 10, 4);
    chk("t1_setup", (t_r1_a - t_csf_a) / 10, 4);
    chk("t1_hold", (t_csr_a - t_fall_a) / 10, 4);
    chk("t1_cs_idle", spi_a.cs_n, 1'b1);

    // 2: device 2 bad status
    frame_a = mk_frame(4, 8, 2);
    vcnt_a = 0;
    pulse_drdy_a();
    wait_valid_a("t2_valid", 5000);
    chk("t2_data", data_out_a, frame_a);
    chk("t2_status", status_ok_a, 4'b1011);
    chk("t2_txn", txn_count_a, 16'd2);
    repeat (10) @(negedge clk);
    chk("t2_vcnt", vcnt_a, 1);

    // 3: overrun at bit 400, then clear
    frame_a = mk_frame(4, 8, -1);
    vcnt_a = 0;
    pulse_drdy_a();
    wait_bit_a("t3_bit400", 400);
    pulse_drdy_a();
    chk("t3_overrun", overrun_a, 1'b1);
    chk("t3_ovr_cnt", overrun_count_a, 16'd1);
    wait_valid_a("t3_valid", 5000);
    chk("t3_data", data_out_a, frame_a);
    repeat (10) @(negedge clk);
    chk("t3_vcnt", vcnt_a, 1);
    chk("t3_txn", txn_count_a, 16'd3);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("t3_clr_overrun", overrun_a, 1'b0);
    chk("t3_clr_cnt", overrun_count_a, 16'd1);

    // 4: enable gate
    enable = 1'b0;
    csf_cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_drdy_a();
      repeat (10) @(negedge clk);
    end
    chk("t4_no_cs", csf_cnt_a, 0);
    chk("t4_cs_n", spi_a.cs_n, 1'b1);
    chk("t4_txn", txn_count_a, 16'd3);
    enable = 1'b1;
    frame_a = mk_frame(4, 8, 1);
    pulse_drdy_a();
    wait_bit_a("t4_bit100", 100);
    enable = 1'b0;
    wait_valid_a("t4_valid", 5000);
    chk("t4_data", data_out_a, frame_a);
    chk("t4_status", status_ok_a, 4'b1101);
    chk("t4_txn2", txn_count_a, 16'd4);
    enable = 1'b1;
    repeat (10) @(negedge clk);

    // 5: reset mid-frame, then clean frame
    frame_a = mk_frame(4, 8, -1);
    pulse_drdy_a();
    wait_bit_a("t5_bit400", 400);
    rst_n = 1'b0;
    #1;
    chk("t5_sclk", spi_a.sclk, 1'b0);
    chk("t5_cs_n", spi_a.cs_n, 1'b1);
    chk("t5_valid", data_valid_a, 1'b0);
    chk("t5_data", data_out_a, '0);
    chk("t5_txn", txn_count_a, 16'd0);
    chk("t5_ovr_cnt", overrun_count_a, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame_a = mk_frame(4, 8, 3);
    vcnt_a = 0;
    pulse_drdy_a();
    wait_valid_a("t5_valid2", 5000);
    chk("t5_data2", data_out_a, frame_a);
    chk("t5_status2", status_ok_a, 4'b0111);
    chk("t5_txn2", txn_count_a, 16'd1);
    repeat (10) @(negedge clk);
    chk("t5_vcnt", vcnt_a, 1);

    // 6: small chain, CLK_DIV=1, txn_count wrap from FFFF
    tmp = mk_frame(1, 4, -1);
    frame_b = tmp[FB_B-1:0];
    vcnt_b = 0;
    pulse_drdy_b();
    wait_valid_b("t6_valid", 1000);
    chk("t6_data", data_out_b, frame_b);
    chk("t6_status", status_ok_b, 1'b1);
    chk("t6_txn_wrap", txn_count_b, 16'h0000);
    repeat (10) @(negedge clk);
    chk("t6_vcnt", vcnt_b, 1);
    chk("t6_rises", rise_b, 120);
    chk("t6_period", (t_r2_b - t_r1_b) / 10, 2);
    chk("t6_setup", (t_r1_b - t_csf_b) / 10, 4);
    chk("t6_hold", (t_csr_b - t_fall_b) / 10, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
